mux_scan_sequencer: RTL



---
 rtl/mux_scan_pkg.sv | 49 ++++
 rtl/mux_scan_sequencer_settle_counter.sv | 36 +++
 rtl/mux_scan_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and helpers for the mux scan sequencer.
// Optional feature macro used by the consumers of this package: SCAN_MASK_EN.
package mux_scan_pkg;

  // Number of mux data inputs and the width of the select bus that addresses them.
  localparam int NUM_CHANNELS = 4;
  localparam int SEL_W        = 2;

  // State encodings, kept as plain constants so legacy code can compare against them.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    SAMPLE = ST_SAMPLE,
    DONE   = ST_DONE
  } scan_state_e;

  // Result of a channel search: whether an enabled channel exists, and which one.
  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } chan_pick_t;

  // Settle counter width: wide enough to hold the settle count, never zero bits.
  function automatic int cnt_width(input int settle);
    return (settle < 2) ? 1 : $clog2(settle + 1);
  endfunction

  // Lowest enabled channel whose number is >= from. from may be NUM_CHANNELS,
  // which yields found=0 and signals that the scan has run out of channels.
  function automatic chan_pick_t next_enabled(input logic [NUM_CHANNELS-1:0] mask,
                                              input logic [SEL_W:0]          from);
    chan_pick_t pick;
    pick = '0;
    // Walk downwards so the lowest qualifying channel is the one left standing.
    for (int c = NUM_CHANNELS - 1; c >= 0; c--) begin
      if (mask[c] && (c >= int'(from))) begin
        pick.found = 1'b1;
        pick.idx   = SEL_W'(c);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_settle_counter.sv
// settle_counter: loadable down-counter that times the dwell on each mux channel.
// The zero flag is asserted while the decrement in progress brings the count to
// zero, so the owner can leave the dwell on exactly the edge the count expires.
// Used by mux_scan_sequencer (optional feature macro there: SCAN_MASK_EN).
module settle_counter
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CNT_W = cnt_width(SETTLE_CYCLES);

  logic [CNT_W-1:0] count_q;

  // Load the full settle count on request, otherwise count down and stop at zero.
  // NOTE: clocked state uses <= so every register samples pre-edge values; a blocking
  // assignment here would let later reads in the same block see the new value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= CNT_W'(SETTLE_CYCLES);
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero = (count_q <= CNT_W'(1));

endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps the 4:1 mux selects through channels 0..3, dwells
// SETTLE_CYCLES on each, samples mux_out, and hands the 4-bit word out over a
// valid/ready handshake.
// Optional feature macro: SCAN_MASK_EN adds chan_mask; disabled channels are
// skipped without spending cycles and read back as 0.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    mux_out,
  output logic                    s1,
  output logic                    s0,
  output logic                    busy,
  output logic [NUM_CHANNELS-1:0] result,
  output logic                    result_valid,
  input  logic                    result_ready
`ifdef SCAN_MASK_EN
  ,
  input  logic [NUM_CHANNELS-1:0] chan_mask
`endif
);

  // With no settle time the dwell collapses and every channel goes straight to SAMPLE.
  localparam scan_state_e DWELL_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_CHANNELS - 1);

  scan_state_e               state_q;
  logic [SEL_W-1:0]          idx_q;
  logic [SEL_W-1:0]          sel_q;
  logic [NUM_CHANNELS-1:0]   result_q;
  chan_pick_t                first_pick;
  chan_pick_t                next_pick;
  logic                      cnt_load;
  logic                      cnt_dec;
  logic                      cnt_zero;

`ifdef SCAN_MASK_EN
  logic [NUM_CHANNELS-1:0]   mask_q;

  // Capture the channel mask on the start edge so it stays fixed for the whole scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      mask_q <= chan_mask;
    end
  end
`endif

  // Decide which channel a new scan starts on and which channel follows the current one.
  // NOTE: every output of a combinational block gets a value on every path (defaults
  // first), otherwise synthesis has to remember the old value and infers a latch.
  always_comb begin
    first_pick = '0;
    next_pick  = '0;
`ifdef SCAN_MASK_EN
    first_pick = next_enabled(chan_mask, '0);
    next_pick  = next_enabled(mask_q, {1'b0, idx_q} + (SEL_W + 1)'(1));
`else
    first_pick.found = 1'b1;
    first_pick.idx   = '0;
    next_pick.found  = (idx_q != SEL_LAST);
    next_pick.idx    = idx_q + SEL_W'(1);
`endif
  end

  // Reload the settle counter whenever a channel's dwell begins; count down while settling.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      IDLE:    cnt_load = start;
      SETTLE:  cnt_dec  = 1'b1;
      SAMPLE:  cnt_load = next_pick.found;
      default: ;
    endcase
  end

  settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_counter (
    .clk  (clk),
    .rst_n(rst_n),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  // Scan sequencer: select stepping, sampling into the result word, and the output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sel_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            result_q <= '0;
            idx_q    <= first_pick.idx;
            if (first_pick.found) begin
              sel_q   <= first_pick.idx;
              state_q <= DWELL_STATE;
            end else begin
              // Nothing enabled: the (empty) word is ready one edge after start.
              sel_q   <= SEL_LAST;
              state_q <= DONE;
            end
          end
        end
        SETTLE: begin
          if (cnt_zero) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          result_q[idx_q] <= mux_out;
          if (next_pick.found) begin
            // Select moves on the sampling edge, so the next dwell starts immediately.
            idx_q   <= next_pick.idx;
            sel_q   <= next_pick.idx;
            state_q <= DWELL_STATE;
          end else begin
            sel_q   <= SEL_LAST;
            state_q <= DONE;
          end
        end
        DONE: begin
          // start is deliberately ignored here, including on the handshake edge.
          if (result_ready) begin
            sel_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {s1, s0}     = sel_q;
  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;

endmodule
